gf_result_rx: RTL and testbench

Receiver and checker for the GF result stream. Sits on GF's output port and consumes each `out_valid` burst of polygon vertices plus the accompanying `out_area`. It independently recomputes the polygon area with an incremental shoelace accumulator and emits a single-cycle report: area, vertex count and error flags. It serves as the on-chip consumer and self-check for GF results.

---
 rtl/gf_pkg.sv | 21 ++
 rtl/gf_cross_term.sv | 27 ++
 rtl/gf_result_rx.sv | 174 +++++++++++++++++
 tb/tb_gf_result_rx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared types and constants for the GF result receiver.
`timescale 1ns/1ps
package gf_pkg;
    localparam int COORD_W = 10;
    localparam int AREA_W  = 25;
    localparam int CNT_W   = 5;
    // Signed width holding x*y - x*y for unsigned COORD_W operands.
    localparam int CROSS_W = 2*COORD_W + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        CLOSE  = 2'd2,
        REPORT = 2'd3
    } gf_rx_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } gf_pt_t;
endpackage

// File: rtl/gf_cross_term.sv
// Combinational shoelace cross term a.x*b.y - b.x*a.y on zero-extended coordinates.
`timescale 1ns/1ps
module gf_cross_term
    import gf_pkg::*;
(
    input  gf_pt_t                     a,
    input  gf_pt_t                     b,
    output logic signed [CROSS_W-1:0]  term
);
    localparam int PAD = CROSS_W - COORD_W;

    logic signed [CROSS_W-1:0] ax;
    logic signed [CROSS_W-1:0] ay;
    logic signed [CROSS_W-1:0] bx;
    logic signed [CROSS_W-1:0] by;
    logic signed [CROSS_W-1:0] p0;
    logic signed [CROSS_W-1:0] p1;

    assign ax = $signed({{PAD{1'b0}}, a.x});
    assign ay = $signed({{PAD{1'b0}}, a.y});
    assign bx = $signed({{PAD{1'b0}}, b.x});
    assign by = $signed({{PAD{1'b0}}, b.y});

    assign p0   = ax * by;
    assign p1   = bx * ay;
    assign term = p0 - p1;
endmodule

// File: rtl/gf_result_rx.sv
// GF result stream receiver: counts vertices, optionally recomputes the shoelace area,
// and emits a one-cycle report per burst. Area recomputation built when GF_RX_AREA_CHECK_EN is defined.
`timescale 1ns/1ps
module gf_result_rx
    import gf_pkg::*;
#(
    parameter int MAX_PTS = 16,
    parameter int SUM_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               out_valid,
    input  logic [COORD_W-1:0] out_x,
    input  logic [COORD_W-1:0] out_y,
    input  logic [AREA_W-1:0]  out_area,
    output logic               rpt_valid,
    output logic [AREA_W-1:0]  rpt_area,
    output logic [CNT_W-1:0]   rpt_cnt,
    output logic               rpt_err,
    output logic               rpt_ovf,
    output logic               rpt_drop,
    output gf_rx_state_t       dbg_state
);
    gf_rx_state_t state;
    gf_rx_state_t next_state;

    logic start_burst;
    logic take_beat;
    logic do_close;
    logic clear_drop;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [31:0]       cnt_ext;
    logic              acc_en;
    logic              few_pts;
    logic              ovf;
    logic [AREA_W-1:0] cap_area;
    logic              drop_q;
    logic [AREA_W-1:0] rpt_area_next;
    logic              area_bad;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (out_valid) next_state = RECV;
            RECV:    if (!out_valid) next_state = CLOSE;
            CLOSE:   next_state = REPORT;
            REPORT:  next_state = out_valid ? RECV : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        start_burst = 1'b0;
        take_beat   = 1'b0;
        do_close    = 1'b0;
        clear_drop  = 1'b0;
        case (state)
            IDLE:   start_burst = out_valid;
            RECV:   take_beat   = out_valid;
            CLOSE:  do_close    = 1'b1;
            REPORT: begin
                start_burst = out_valid;
                clear_drop  = 1'b1;
            end
            default: ;
        endcase
    end

    assign dbg_state = state;

    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    assign cnt_ext = {{(32-CNT_W){1'b0}}, cnt};
    // Only vertices that keep the count within MAX_PTS feed the accumulator.
    assign acc_en  = take_beat && (cnt_ext < 32'(MAX_PTS));
    assign few_pts = cnt < 5'd3;
    assign ovf     = cnt_ext > 32'(MAX_PTS);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            cap_area <= '0;
        end else if (start_burst) begin
            cnt      <= 5'd1;
            cap_area <= out_area;
        end else if (take_beat) begin
            cnt      <= cnt_inc;
        end
    end

`ifdef GF_RX_AREA_CHECK_EN
    gf_pt_t                     first_pt;
    gf_pt_t                     prev_pt;
    gf_pt_t                     beat_pt;
    gf_pt_t                     b_sel;
    logic signed [CROSS_W-1:0]  term;
    logic signed [SUM_W-1:0]    term_ext;
    logic signed [SUM_W-1:0]    sum;
    logic signed [SUM_W-1:0]    sum_fin;
    logic [SUM_W-1:0]           mag;
    logic                       unused_mag;

    assign beat_pt = '{x: out_x, y: out_y};
    // One cross-term unit: the closing edge reuses it with the first vertex as operand.
    assign b_sel   = (state == CLOSE) ? first_pt : beat_pt;

    gf_cross_term u_cross (
        .a    (prev_pt),
        .b    (b_sel),
        .term (term)
    );

    assign term_ext = {{(SUM_W-CROSS_W){term[CROSS_W-1]}}, term};
    assign sum_fin  = sum + term_ext;
    assign mag      = sum_fin[SUM_W-1] ? (~sum_fin + 1'b1) : sum_fin;

    assign rpt_area_next = mag[AREA_W:1];
    assign area_bad      = rpt_area_next != cap_area;
    assign unused_mag    = ^{mag[SUM_W-1:AREA_W+1], mag[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            first_pt <= '0;
            prev_pt  <= '0;
            sum      <= '0;
        end else if (start_burst) begin
            first_pt <= beat_pt;
            prev_pt  <= beat_pt;
            sum      <= '0;
        end else if (acc_en) begin
            prev_pt  <= beat_pt;
            sum      <= sum_fin;
        end
    end
`else
    logic             unused_coords;
    logic [SUM_W-1:0] unused_sum_w;

    assign rpt_area_next = cap_area;
    assign area_bad      = 1'b0;
    assign unused_coords = ^{out_x, out_y, acc_en};
    assign unused_sum_w  = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_valid <= 1'b0;
            rpt_area  <= '0;
            rpt_cnt   <= '0;
            rpt_err   <= 1'b0;
            rpt_ovf   <= 1'b0;
            rpt_drop  <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            rpt_valid <= do_close;
            if (do_close) begin
                rpt_area <= rpt_area_next;
                rpt_cnt  <= cnt;
                rpt_err  <= area_bad | few_pts;
                rpt_ovf  <= ovf;
                rpt_drop <= drop_q | out_valid;
                drop_q   <= drop_q | out_valid;
            end else if (clear_drop) begin
                drop_q   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_gf_result_rx.sv
// Scoreboard bench for gf_result_rx: directed bursts push expected reports, a monitor pops and compares.
`timescale 1ns/1ps
module tb_gf_result_rx;
    import gf_pkg::*;

    localparam int RPT_W = AREA_W + CNT_W + 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               out_valid;
    logic [COORD_W-1:0] out_x;
    logic [COORD_W-1:0] out_y;
    logic [AREA_W-1:0]  out_area;
    logic               rpt_valid;
    logic [AREA_W-1:0]  rpt_area;
    logic [CNT_W-1:0]   rpt_cnt;
    logic               rpt_err;
    logic               rpt_ovf;
    logic               rpt_drop;
    gf_rx_state_t       dbg_state;

    int checks = 0;
    int errors = 0;
    logic [RPT_W-1:0] exp_q[$];

    gf_result_rx #(.MAX_PTS(16), .SUM_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .out_valid (out_valid),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_area  (out_area),
        .rpt_valid (rpt_valid),
        .rpt_area  (rpt_area),
        .rpt_cnt   (rpt_cnt),
        .rpt_err   (rpt_err),
        .rpt_ovf   (rpt_ovf),
        .rpt_drop  (rpt_drop),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #50000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        out_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic beat(input int x, input int y, input int area);
        out_valid = 1'b1;
        out_x     = COORD_W'(x);
        out_y     = COORD_W'(y);
        out_area  = AREA_W'(area);
        tick();
    endtask

    task automatic expect_rpt(input int area, input int cnt, input bit err, input bit ovf, input bit drop);
        exp_q.push_back({AREA_W'(area), CNT_W'(cnt), err, ovf, drop});
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic square_cw(input int area);
        beat(0, 0, area);
        beat(0, 10, area);
        beat(10, 10, area);
        beat(10, 0, area);
    endtask

    task automatic square_ccw(input int area);
        beat(0, 0, area);
        beat(10, 0, area);
        beat(10, 10, area);
        beat(0, 10, area);
    endtask

    // Monitor: every report strobe pops one expected entry
    always @(negedge clk) begin
        logic [RPT_W-1:0] act;
        logic [RPT_W-1:0] exp;
        if (rpt_valid) begin
            act = {rpt_area, rpt_cnt, rpt_err, rpt_ovf, rpt_drop};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_report: got {area,cnt,err,ovf,drop}=%0h, required no report", act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL report: got area=%0d cnt=%0d err=%0b ovf=%0b drop=%0b, required area=%0d cnt=%0d err=%0b ovf=%0b drop=%0b",
                             act[RPT_W-1:8], act[7:3], act[2], act[1], act[0],
                             exp[RPT_W-1:8], exp[7:3], exp[2], exp[1], exp[0]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        rst       = 1'b1;
        out_valid = 1'b0;
        out_x     = '0;
        out_y     = '0;
        out_area  = '0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", 64'({rpt_valid, rpt_area, rpt_cnt, rpt_err, rpt_ovf, rpt_drop}), 64'd0);
        check("reset_state", 64'(dbg_state), 64'(IDLE));

        // Clockwise square with latency measured from the first low cycle
        expect_rpt(100, 4, 1'b0, 1'b0, 1'b0);
        square_cw(100);
        out_valid = 1'b0;
        @(negedge clk);
        check("latency_c0", 64'(rpt_valid), 64'd0);
        tick();
        @(negedge clk);
        check("latency_c1", 64'(rpt_valid), 64'd0);
        tick();
        @(negedge clk);
        check("latency_c2", 64'(rpt_valid), 64'd1);
        idle(3);

        // Counter-clockwise order gives the same area
        expect_rpt(100, 4, 1'b0, 1'b0, 1'b0);
        square_ccw(100);
        idle(4);

        // Triangle with a wrong reported area
`ifdef GF_RX_AREA_CHECK_EN
        expect_rpt(6, 3, 1'b1, 1'b0, 1'b0);
`else
        expect_rpt(7, 3, 1'b0, 1'b0, 1'b0);
`endif
        beat(0, 0, 7);
        beat(4, 0, 7);
        beat(0, 3, 7);
        idle(4);

        // Full coordinate range, no accumulator wrap
        expect_rpt(1046529, 4, 1'b0, 1'b0, 1'b0);
        beat(0, 0, 1046529);
        beat(1023, 0, 1046529);
        beat(1023, 1023, 1046529);
        beat(0, 1023, 1046529);
        idle(4);

        // Single-beat burst
        expect_rpt(0, 1, 1'b1, 1'b0, 1'b0);
        beat(5, 5, 0);
        idle(4);

        // Overflow burst, then a short burst that clears ovf
        expect_rpt(0, 18, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 18; i++) beat(5, 5, 0);
        idle(4);
        expect_rpt(0, 2, 1'b1, 1'b0, 1'b0);
        beat(1, 2, 0);
        beat(3, 4, 0);
        idle(4);

        // One-cycle gap: next beat 0 lands in CLOSE and is dropped
        expect_rpt(100, 4, 1'b0, 1'b0, 1'b1);
        expect_rpt(6, 3, 1'b0, 1'b0, 1'b0);
        square_cw(100);
        idle(1);
        beat(7, 7, 6);
        beat(0, 0, 6);
        beat(4, 0, 6);
        beat(0, 3, 6);
        idle(4);

        // Two-cycle gap: next beat 0 is accepted in REPORT
        expect_rpt(100, 4, 1'b0, 1'b0, 1'b0);
        expect_rpt(100, 4, 1'b0, 1'b0, 1'b0);
        square_cw(100);
        idle(2);
        square_ccw(100);
        idle(4);

        // Reset on beat 2 aborts the burst without a report
        beat(0, 0, 100);
        beat(0, 10, 100);
        out_valid = 1'b1;
        out_x     = 10'd10;
        out_y     = 10'd10;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        out_valid = 1'b0;
        @(negedge clk);
        check("midburst_reset_outputs", 64'({rpt_valid, rpt_area, rpt_cnt, rpt_err, rpt_ovf, rpt_drop}), 64'd0);
        check("midburst_reset_state", 64'(dbg_state), 64'(IDLE));
        idle(6);

        // Clean burst after reset
        expect_rpt(100, 4, 1'b0, 1'b0, 1'b0);
        square_cw(100);
        idle(6);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
